axis_step_shaper: RTL

AXIS_STEP_SHAPER -- requirements
Module: axis_step_shaper

---
 rtl/axis_step_shaper.sv | 129 ++++++++++++
 1 files changed

// File: rtl/axis_step_shaper.sv
// Shapes step requests into timed step/dir pulses for a stepper driver. It enforces
// direction setup time and min/max pulse widths, and tracks a signed position within limits.
module axis_step_shaper #(
  parameter int DIR_SETUP_CYC  = 200,
  parameter int PULSE_HIGH_CYC = 80,
  parameter int PULSE_LOW_CYC  = 80,
  parameter int POS_W          = 16,
  parameter int POS_MIN        = -1000,
  parameter int POS_MAX        = 1000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    step_req,
  input  logic                    dir_req,
  input  logic                    enable,
  input  logic                    endstop,
  input  logic                    zero_pos,
  output logic                    step_ready,
  output logic                    dir_out,
  output logic                    step_out,
  output logic signed [POS_W-1:0] position,
  output logic                    busy,
  output logic                    req_dropped
);

  // state      | meaning
  // IDLE       | waiting for a request, step_ready may be high
  // DIR_SETUP  | dir_out changed, holding it before the step edge
  // PULSE_HIGH | step_out high
  // PULSE_LOW  | step_out low, enforcing minimum low time
  typedef enum logic [1:0] {IDLE, DIR_SETUP, PULSE_HIGH, PULSE_LOW} state_t;

  localparam int MAX_HL  = (PULSE_HIGH_CYC > PULSE_LOW_CYC) ? PULSE_HIGH_CYC : PULSE_LOW_CYC;
  localparam int MAX_CYC = (DIR_SETUP_CYC > MAX_HL) ? DIR_SETUP_CYC : MAX_HL;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] L_DS = CNT_W'(DIR_SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] L_PH = CNT_W'(PULSE_HIGH_CYC - 1);
  localparam logic [CNT_W-1:0] L_PL = CNT_W'(PULSE_LOW_CYC - 1);
  localparam logic [CNT_W-1:0] L_C1 = CNT_W'(1);

  localparam logic signed [POS_W-1:0] L_MIN = POS_W'(POS_MIN);
  localparam logic signed [POS_W-1:0] L_MAX = POS_W'(POS_MAX);
  localparam logic signed [POS_W-1:0] L_P1  = POS_W'(1);

  state_t                    r_state, w_state_nxt;
  logic [CNT_W-1:0]          r_cnt, w_cnt_nxt;
  logic                      r_dir, w_dir_nxt;
  logic signed [POS_W-1:0]   r_pos, w_pos_step;
  logic                      r_drop;
  logic                      w_blocked, w_accept, w_reject, w_step_rise;

  assign step_ready = (r_state == IDLE) && enable && !rst;
  assign w_blocked  = (!dir_req && (endstop || (r_pos == L_MIN))) ||
                      ( dir_req && (r_pos == L_MAX));
  assign w_accept   = step_req && step_ready && !w_blocked;
  assign w_reject   = step_req && !w_accept;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_dir_nxt   = r_dir;
    w_step_rise = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_dir_nxt = dir_req;
          if (dir_req != r_dir) begin
            w_state_nxt = DIR_SETUP;
            w_cnt_nxt   = L_DS;
          end else begin
            w_state_nxt = PULSE_HIGH;
            w_cnt_nxt   = L_PH;
            w_step_rise = 1'b1;
          end
        end
      end
      DIR_SETUP: begin
        if (r_cnt == '0) begin
          w_state_nxt = PULSE_HIGH;
          w_cnt_nxt   = L_PH;
          w_step_rise = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - L_C1;
        end
      end
      PULSE_HIGH: begin
        if (r_cnt == '0) begin
          w_state_nxt = PULSE_LOW;
          w_cnt_nxt   = L_PL;
        end else begin
          w_cnt_nxt = r_cnt - L_C1;
        end
      end
      PULSE_LOW: begin
        if (r_cnt == '0) w_state_nxt = IDLE;
        else             w_cnt_nxt   = r_cnt - L_C1;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Position moves in the direction that will be on dir_out when the step edge appears.
  assign w_pos_step = w_dir_nxt ? (r_pos + L_P1) : (r_pos - L_P1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_dir   <= 1'b0;
      r_pos   <= '0;
      r_drop  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_dir   <= w_dir_nxt;
      r_drop  <= w_reject;
      if (zero_pos)         r_pos <= '0;
      else if (w_step_rise) r_pos <= w_pos_step;
    end
  end

  assign dir_out     = r_dir;
  assign step_out    = (r_state == PULSE_HIGH);
  assign position    = r_pos;
  assign busy        = (r_state != IDLE);
  assign req_dropped = r_drop;

endmodule
